// File: rtl/alu_muldiv.sv
// Registered execute-stage ALU with iterative RV32M multiply/divide/remainder.
// Single-cycle ops and divide corner cases finish in one cycle; mul/div take WIDTH iterations.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops and divide fast paths complete here
// CALC  | one shift-add / restoring shift-subtract iteration per cycle
// DONE  | done pulse, ALUOut valid, start ignored
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [OPW-1:0]   ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_EQ   = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_REM  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_REMU = OPW'(5'b01111);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  hi_q, lo_q, opb_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;

    logic              is_md, fast_div, accept, out_load;
    logic              signed_a, signed_b, a_neg, b_neg, neg_c;
    logic [2:0]        sub_op;
    logic [WIDTH-1:0]  mag_a, mag_b, sc_res, md_res, out_val;
    logic [WIDTH-1:0]  hi_nx, lo_nx, quot, rem;
    logic [WIDTH:0]    mul_sum, r_sh, diff;
    logic [2*WIDTH-1:0] full, prod;

    assign sub_op   = ALUOp[2:0];
    assign is_md    = ((ALUOp >> 3) == OPW'(1));
    assign fast_div = is_md && ALUOp[2] &&
                      ((B == '0) || (!ALUOp[0] && (A == SMIN) && (B == '1)));

    assign signed_a = (sub_op == 3'd1) || (sub_op == 3'd2) || (sub_op == 3'd4) || (sub_op == 3'd6);
    assign signed_b = (sub_op == 3'd1) || (sub_op == 3'd4) || (sub_op == 3'd6);
    assign a_neg    = signed_a && A[WIDTH-1];
    assign b_neg    = signed_b && B[WIDTH-1];
    assign mag_a    = a_neg ? -A : A;
    assign mag_b    = b_neg ? -B : B;
    // Signed remainder follows the dividend; everything else follows the product of signs.
    assign neg_c    = (sub_op[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);

    always_comb begin
        sc_res = '0;
        case (ALUOp)
            OP_ADD:           sc_res = A + B;
            OP_SUB:           sc_res = A - B;
            OP_AND:           sc_res = A & B;
            OP_OR:            sc_res = A | B;
            OP_EQ:            sc_res = (A == B) ? '1 : '0;
            OP_DIV, OP_DIVU:  sc_res = (B == '0) ? '1 : SMIN;
            OP_REM, OP_REMU:  sc_res = (B == '0) ? A : '0;
            default:          sc_res = '0;
        endcase
    end

    // One iteration: mul shifts the {hi,lo} product right, div shifts {rem,quot} left.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign r_sh    = {hi_q, lo_q[WIDTH-1]};
    assign diff    = r_sh - {1'b0, opb_q};

    always_comb begin
        hi_nx = '0;
        lo_nx = '0;
        if (op_q[2]) begin
            hi_nx = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nx = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            hi_nx = mul_sum[WIDTH:1];
            lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign full = {hi_nx, lo_nx};
    assign prod = neg_q ? -full : full;
    assign quot = neg_q ? -lo_nx : lo_nx;
    assign rem  = neg_q ? -hi_nx : hi_nx;

    always_comb begin
        md_res = '0;
        case (op_q)
            3'd0:             md_res = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: md_res = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       md_res = quot;
            default:          md_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        out_load = 1'b0;
        out_val  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_md && !fast_div) begin
                        state_d = CALC;
                        accept  = 1'b1;
                    end else begin
                        state_d  = DONE;
                        out_load = 1'b1;
                        out_val  = sc_res;
                    end
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    out_load = 1'b1;
                    out_val  = md_res;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            accept   = 1'b0;
            out_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            ALUOut <= '0;
        end else begin
            if (accept) begin
                hi_q  <= '0;
                lo_q  <= mag_a;
                opb_q <= mag_b;
                cnt_q <= '0;
                op_q  <= sub_op;
                neg_q <= neg_c;
            end else if (state_q == CALC && !flush) begin
                hi_q  <= hi_nx;
                lo_q  <= lo_nx;
                cnt_q <= cnt_q + 1'b1;
            end
            if (out_load) ALUOut <= out_val;
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
endmodule
